// File: rtl/eight_mem_cof_pkg.sv
// Shared types and defaults for the 8-bank coefficient memory burst arbiter.
package eight_mem_cof_pkg;

  localparam int ADDR_WIDTH_8_MEM = 15;
  localparam int DATA_WIDTH       = 32;
  localparam int LEN_WIDTH        = 8;

  localparam logic REQ_FB  = 1'b0;
  localparam logic REQ_DCT = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/eight_mem_rr_arb2.sv
// Two-way picker: round-robin with a registered pointer, or fixed priority to
// requester 0 when EIGHT_MEM_ARB_FIXED_PRIO_EN is defined.
module eight_mem_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_0,
  input  logic req_1,
  input  logic advance,
  output logic pick,
  output logic any_req
);
  import eight_mem_cof_pkg::*;

  assign any_req = req_0 | req_1;

`ifdef EIGHT_MEM_ARB_FIXED_PRIO_EN
  assign pick = req_0 ? REQ_FB : REQ_DCT;
`else
  logic ptr_q;
  logic ptr_d;

  // The preferred requester wins if it asks; the pointer then moves to the loser.
  always_comb begin
    if (ptr_q == REQ_FB) begin
      pick = req_0 ? REQ_FB : REQ_DCT;
    end else begin
      pick = req_1 ? REQ_DCT : REQ_FB;
    end
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = ~pick;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= REQ_FB;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: rtl/eight_mem_cof_arb.sv
// Burst-read arbiter/sequencer in front of the 8-bank coefficient controller.
// Optional build macro: EIGHT_MEM_ARB_FIXED_PRIO_EN (fixed priority to port 0).
module eight_mem_cof_arb #(
  parameter int ADDR_WIDTH_8_MEM = eight_mem_cof_pkg::ADDR_WIDTH_8_MEM,
  parameter int DATA_WIDTH       = eight_mem_cof_pkg::DATA_WIDTH,
  parameter int LEN_WIDTH        = eight_mem_cof_pkg::LEN_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_0,
  input  logic [ADDR_WIDTH_8_MEM-1:0] addr_0,
  input  logic [LEN_WIDTH-1:0]        len_0,
  output logic                        gnt_0,
  input  logic                        req_1,
  input  logic [ADDR_WIDTH_8_MEM-1:0] addr_1,
  input  logic [LEN_WIDTH-1:0]        len_1,
  output logic                        gnt_1,
  output logic [ADDR_WIDTH_8_MEM-1:0] mem_addr,
  output logic                        mem_cen_sel,
  input  logic [DATA_WIDTH-1:0]       mem_rd_data,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_valid,
  output logic                        rd_id,
  output logic                        rd_last,
  output logic                        busy
);
  import eight_mem_cof_pkg::*;

  state_e                      state_q, state_d;
  logic [ADDR_WIDTH_8_MEM-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
  logic                        owner_q, owner_d;
  logic                        gnt_0_q, gnt_0_d;
  logic                        gnt_1_q, gnt_1_d;
  logic [ADDR_WIDTH_8_MEM-1:0] mem_addr_q, mem_addr_d;
  logic                        cen_q, cen_d;
  logic                        iss_owner_q, iss_owner_d;
  logic                        iss_last_q, iss_last_d;
  logic                        rd_valid_q, rd_valid_d;
  logic                        rd_id_q, rd_id_d;
  logic                        rd_last_q, rd_last_d;
  logic                        pick;
  logic                        any_req;
  logic                        advance;

  eight_mem_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_0   (req_0),
    .req_1   (req_1),
    .advance (advance),
    .pick    (pick),
    .any_req (any_req)
  );

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    gnt_0_d     = 1'b0;
    gnt_1_d     = 1'b0;
    cen_d       = 1'b0;
    iss_owner_d = 1'b0;
    iss_last_d  = 1'b0;
    advance     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          advance    = 1'b1;
          gnt_0_d    = (pick == REQ_FB);
          gnt_1_d    = (pick == REQ_DCT);
          cur_addr_d = (pick == REQ_DCT) ? addr_1 : addr_0;
          cnt_d      = (pick == REQ_DCT) ? len_1 : len_0;
          owner_d    = pick;
          state_d    = BURST;
        end
      end
      BURST: begin
        // Address wraps modulo 2^15, crossing bank 7 into bank 0 with no special case.
        cen_d       = 1'b1;
        mem_addr_d  = cur_addr_q;
        cur_addr_d  = cur_addr_q + ADDR_WIDTH_8_MEM'(1);
        cnt_d       = cnt_q - LEN_WIDTH'(1);
        iss_owner_d = owner_q;
        if (cnt_q == '0) begin
          iss_last_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rd_valid_d = cen_q;
    rd_id_d    = iss_owner_q;
    rd_last_d  = iss_last_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      gnt_0_q     <= 1'b0;
      gnt_1_q     <= 1'b0;
      mem_addr_q  <= '0;
      cen_q       <= 1'b0;
      iss_owner_q <= 1'b0;
      iss_last_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_id_q     <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      gnt_0_q     <= gnt_0_d;
      gnt_1_q     <= gnt_1_d;
      mem_addr_q  <= mem_addr_d;
      cen_q       <= cen_d;
      iss_owner_q <= iss_owner_d;
      iss_last_q  <= iss_last_d;
      rd_valid_q  <= rd_valid_d;
      rd_id_q     <= rd_id_d;
      rd_last_q   <= rd_last_d;
    end
  end

  // Busy covers the issue register and the return stage so it drops after rd_last.
  assign gnt_0       = gnt_0_q;
  assign gnt_1       = gnt_1_q;
  assign mem_addr    = mem_addr_q;
  assign mem_cen_sel = cen_q;
  assign rd_valid    = rd_valid_q;
  assign rd_id       = rd_id_q;
  assign rd_last     = rd_last_q;
  assign rd_data     = rd_valid_q ? mem_rd_data : '0;
  assign busy        = (state_q != IDLE) | cen_q | rd_valid_q;

endmodule

// File: tb/tb_eight_mem_cof_arb.sv
// Directed bench for eight_mem_cof_arb: per-cycle vector table plus multi-cycle sequences.
module tb_eight_mem_cof_arb;

  logic        clk;
  logic        rst_n;
  logic        req_0, req_1;
  logic [14:0] addr_0, addr_1;
  logic [7:0]  len_0, len_1;
  logic        gnt_0, gnt_1;
  logic [14:0] mem_addr;
  logic        mem_cen_sel;
  logic [31:0] mem_rd_data;
  logic [31:0] rd_data;
  logic        rd_valid, rd_id, rd_last, busy;

  int checks;
  int failures;

  eight_mem_cof_arb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_0       (req_0),
    .addr_0      (addr_0),
    .len_0       (len_0),
    .gnt_0       (gnt_0),
    .req_1       (req_1),
    .addr_1      (addr_1),
    .len_1       (len_1),
    .gnt_1       (gnt_1),
    .mem_addr    (mem_addr),
    .mem_cen_sel (mem_cen_sel),
    .mem_rd_data (mem_rd_data),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_id       (rd_id),
    .rd_last     (rd_last),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [14:0] a);
    return 32'hC0E0_0000 | {17'd0, a};
  endfunction

  // Memory model: word for the issued address appears one cycle later.
  always @(posedge clk) begin
    mem_rd_data <= mem_cen_sel ? memword(mem_addr) : 32'h0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r0;
    logic [14:0] a0;
    logic [7:0]  l0;
    logic        r1;
    logic [14:0] a1;
    logic [7:0]  l1;
    logic        g0;
    logic        g1;
    logic        cen;
    logic [14:0] maddr;
    logic        rv;
    logic        rid;
    logic        rlast;
    logic        bsy;
    logic [31:0] rdat;
  } vec_t;

  function automatic vec_t mk(input logic r0, input logic [14:0] a0, input logic [7:0] l0,
                              input logic r1, input logic [14:0] a1, input logic [7:0] l1,
                              input logic g0, input logic g1, input logic cen,
                              input logic [14:0] maddr, input logic rv, input logic rid,
                              input logic rlast, input logic bsy, input logic [31:0] rdat);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.l0 = l0; v.r1 = r1; v.a1 = a1; v.l1 = l1;
    v.g0 = g0; v.g1 = g1; v.cen = cen; v.maddr = maddr; v.rv = rv; v.rid = rid;
    v.rlast = rlast; v.bsy = bsy; v.rdat = rdat;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    req_0 = v.r0; addr_0 = v.a0; len_0 = v.l0;
    req_1 = v.r1; addr_1 = v.a1; len_1 = v.l1;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    check($sformatf("v%0d gnt_0", idx), 32'(gnt_0), 32'(v.g0));
    check($sformatf("v%0d gnt_1", idx), 32'(gnt_1), 32'(v.g1));
    check($sformatf("v%0d cen", idx), 32'(mem_cen_sel), 32'(v.cen));
    check($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(v.maddr));
    check($sformatf("v%0d rd_valid", idx), 32'(rd_valid), 32'(v.rv));
    check($sformatf("v%0d rd_last", idx), 32'(rd_last), 32'(v.rlast));
    check($sformatf("v%0d busy", idx), 32'(busy), 32'(v.bsy));
    if (v.rv) begin
      check($sformatf("v%0d rd_id", idx), 32'(rd_id), 32'(v.rid));
      check($sformatf("v%0d rd_data", idx), rd_data, v.rdat);
    end
  endtask

  vec_t vecs[12];
  int   order[4];

  initial begin
    int ng, nis, last_iss, gcyc, rvcnt, lastcnt, lastcyc, fallcyc;
    logic cur_owner;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    req_0 = 1'b0; req_1 = 1'b0;
    addr_0 = '0; addr_1 = '0; len_0 = '0; len_1 = '0;

    // Single burst across a bank boundary, then a wrapping burst from port 1.
    vecs[0]  = mk(1, 15'h0FFE, 3, 0, 0, 0,          1, 0, 0, 15'h0000, 0, 0, 0, 1, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0,                  0, 0, 1, 15'h0FFE, 0, 0, 0, 1, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0,                  0, 0, 1, 15'h0FFF, 1, 0, 0, 1, memword(15'h0FFE));
    vecs[3]  = mk(0, 0, 0, 0, 0, 0,                  0, 0, 1, 15'h1000, 1, 0, 0, 1, memword(15'h0FFF));
    vecs[4]  = mk(0, 0, 0, 0, 0, 0,                  0, 0, 1, 15'h1001, 1, 0, 0, 1, memword(15'h1000));
    vecs[5]  = mk(0, 0, 0, 0, 0, 0,                  0, 0, 0, 15'h1001, 1, 0, 1, 1, memword(15'h1001));
    vecs[6]  = mk(0, 0, 0, 0, 0, 0,                  0, 0, 0, 15'h1001, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 1, 15'h7FFF, 1,           0, 1, 0, 15'h1001, 0, 0, 0, 1, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0,                  0, 0, 1, 15'h7FFF, 0, 0, 0, 1, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0,                  0, 0, 1, 15'h0000, 1, 1, 0, 1, memword(15'h7FFF));
    vecs[10] = mk(0, 0, 0, 0, 0, 0,                  0, 0, 0, 15'h0000, 1, 1, 1, 1, memword(15'h0000));
    vecs[11] = mk(0, 0, 0, 0, 0, 0,                  0, 0, 0, 15'h0000, 0, 0, 0, 0, 0);

    tick();
    tick();
    check("reset gnt_0", 32'(gnt_0), 0);
    check("reset gnt_1", 32'(gnt_1), 0);
    check("reset cen", 32'(mem_cen_sel), 0);
    check("reset mem_addr", 32'(mem_addr), 0);
    check("reset rd_valid", 32'(rd_valid), 0);
    check("reset rd_last", 32'(rd_last), 0);
    check("reset rd_id", 32'(rd_id), 0);
    check("reset busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput(vecs[i], i);
    end

    // Contention: both held, len 0, four grants.
    req_0 = 1; addr_0 = 15'h0400; len_0 = 0;
    req_1 = 1; addr_1 = 15'h0500; len_1 = 0;
    ng = 0; nis = 0; last_iss = -1; cur_owner = 0;
    for (int c = 0; c < 40 && nis < 4; c++) begin
      tick();
      if (gnt_0 && gnt_1) check("cont dual gnt", 1, 0);
      if (mem_cen_sel) begin
        if (last_iss >= 0) check("cont issue spacing", 32'(c - last_iss), 2);
        check("cont issue addr", 32'(mem_addr), cur_owner ? 32'h0500 : 32'h0400);
        last_iss = c;
        nis++;
      end
      if ((gnt_0 || gnt_1) && ng < 4) begin
        order[ng] = gnt_1 ? 1 : 0;
        cur_owner = gnt_1;
        ng++;
        if (ng == 4) begin
          req_0 = 0; req_1 = 0;
        end
      end
    end
    req_0 = 0; req_1 = 0;
    check("cont grant count", 32'(ng), 4);
    check("cont issue count", 32'(nis), 4);
    for (int i = 0; i < 4; i++) begin
`ifdef EIGHT_MEM_ARB_FIXED_PRIO_EN
      check($sformatf("cont order %0d", i), 32'(order[i]), 0);
`else
      check($sformatf("cont order %0d", i), 32'(order[i]), 32'(i % 2));
`endif
    end
    repeat (3) tick();

    // Late request from port 1 during a len 7 burst of port 0.
    req_0 = 1; addr_0 = 15'h0100; len_0 = 7;
    tick();
    check("late gnt_0", 32'(gnt_0), 1);
    req_0 = 0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      check($sformatf("late k%0d gnt_1", k), 32'(gnt_1), 32'(k == 9));
      check($sformatf("late k%0d cen", k), 32'(mem_cen_sel), 32'((k >= 1 && k <= 8) || k == 10));
      check($sformatf("late k%0d rd_valid", k), 32'(rd_valid), 32'((k >= 2 && k <= 9) || k == 11));
      if (k >= 1 && k <= 8) check($sformatf("late k%0d addr", k), 32'(mem_addr), 32'(15'h0100 + k - 1));
      if (k == 10) check("late dct addr", 32'(mem_addr), 32'h0200);
      if (rd_valid) check($sformatf("late k%0d rd_id", k), 32'(rd_id), 32'(k == 11));
      if (k == 3) begin
        req_1 = 1; addr_1 = 15'h0200; len_1 = 0;
      end
      if (gnt_1) req_1 = 0;
    end
    req_1 = 0;
    repeat (2) tick();

    // Reset during the third issue of a len 7 burst.
    req_0 = 1; addr_0 = 15'h0300; len_0 = 7;
    tick();
    check("rst gnt_0", 32'(gnt_0), 1);
    req_0 = 0;
    repeat (3) tick();
    check("rst 3rd issue addr", 32'(mem_addr), 32'h0302);
    rst_n = 0;
    tick();
    check("rst gnt_0 out", 32'(gnt_0), 0);
    check("rst cen out", 32'(mem_cen_sel), 0);
    check("rst mem_addr out", 32'(mem_addr), 0);
    check("rst rd_valid out", 32'(rd_valid), 0);
    check("rst rd_last out", 32'(rd_last), 0);
    check("rst rd_data out", rd_data, 0);
    check("rst busy out", 32'(busy), 0);
    rst_n = 1;
    rvcnt = 0;
    repeat (10) begin
      tick();
      rvcnt += int'(rd_valid) + int'(mem_cen_sel) + int'(busy);
    end
    check("rst no activity after", 32'(rvcnt), 0);

    // Maximum length burst.
    req_0 = 1; addr_0 = 15'h0000; len_0 = 8'd255;
    gcyc = -1;
    for (int c = 0; c < 10 && gcyc < 0; c++) begin
      tick();
      if (gnt_0) gcyc = c;
    end
    req_0 = 0;
    check("max gnt seen", 32'(gcyc >= 0), 1);
    rvcnt = 0; lastcnt = 0; lastcyc = -1; fallcyc = -1;
    for (int c = 0; c < 400 && fallcyc < 0; c++) begin
      tick();
      if (rd_valid) rvcnt++;
      if (rd_last) begin
        lastcnt++;
        lastcyc = c;
        check("max last data", rd_data, memword(15'h00FF));
        check("max last valid", 32'(rd_valid), 1);
      end
      if (lastcyc >= 0 && !busy) fallcyc = c;
    end
    check("max rd_valid count", 32'(rvcnt), 256);
    check("max rd_last count", 32'(lastcnt), 1);
    check("max busy fall", 32'(fallcyc - lastcyc), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
